axis_pack_fifo: RTL

// - Parametrised AXIS FIFO between a FINN stitched-IP output (narrow samples, no TLAST) and a Xilinx AXI DMA S2MM port.
// - Optionally packs several narrow input samples into one wide output beat.
// - Generates TLAST from a compile-time frame length, so every DMA transfer closes on a frame boundary.

---
 rtl/axis_fifo_pkg.sv | 25 ++
 rtl/axis_sync_fifo.sv | 71 +++++++
 rtl/axis_pack_fifo.sv | 127 ++++++++++++
 3 files changed

// File: rtl/axis_fifo_pkg.sv
// Shared helpers for the AXIS pack FIFO: pointer/lane width functions and elaboration-time parameter checks.
// Used by axis_sync_fifo and axis_pack_fifo (optional tkeep support is selected with AXIS_TKEEP_EN).
`ifndef AXIS_FIFO_PKG_SV
`define AXIS_FIFO_PKG_SV

// Elaboration-time guard: instantiates a failing generate block when cond is false.
`define AXIS_FIFO_CHECK(label, cond, msg) if (!(cond)) begin : label $error(msg); end

package axis_fifo_pkg;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int lane_w(input int ratio);
        return $clog2(ratio) + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v >= 1) && ((v & (v - 1)) == 0);
    endfunction

endpackage

`endif

// File: rtl/axis_sync_fifo.sv
// Generic synchronous show-ahead FIFO with wrap-bit pointers; the head entry is held in a
// registered read port and is valid whenever the FIFO is not empty.
module axis_sync_fifo
    import axis_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = ptr_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_rd_next;
    logic             w_push;
    logic             w_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]) &&
                   (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]);
    assign count = r_wr_ptr - r_rd_ptr;

    assign w_push    = push && !full;
    assign w_pop     = pop && !empty;
    assign w_rd_next = r_rd_ptr + PTR_W'(w_pop);
    assign rdata     = r_rdata;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[IDX_W-1:0]] <= wdata;
        end
    end

    // Prefetch the entry that will be at the head after this edge; a word written into
    // that very slot this cycle is forwarded so an empty FIFO shows it one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_push && (r_wr_ptr[IDX_W-1:0] == w_rd_next[IDX_W-1:0])) begin
            r_rdata <= wdata;
        end else begin
            r_rdata <= r_mem[w_rd_next[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_rd_next;
        end
    end

endmodule

// File: rtl/axis_pack_fifo.sv
// AXIS FIFO from a narrow TLAST-less sample stream to a wide DMA stream: packs samples into
// beats and closes every frame of FRAME_LEN samples with TLAST. AXIS_TKEEP_EN adds m_axis_tkeep.
module axis_pack_fifo
    import axis_fifo_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int IN_DATA_WIDTH  = 8,
    parameter int OUT_DATA_WIDTH = 32,
    parameter int PACK_MODE      = 1,
    parameter int FRAME_LEN      = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_axis_tvalid,
    input  logic [IN_DATA_WIDTH-1:0]    s_axis_tdata,
    output logic                        s_axis_tready,
    output logic                        m_axis_tvalid,
    output logic [OUT_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready,
`ifdef AXIS_TKEEP_EN
    output logic [OUT_DATA_WIDTH/8-1:0] m_axis_tkeep,
`endif
    output logic [$clog2(DEPTH):0]      fill_level
);

    localparam int RATIO   = OUT_DATA_WIDTH / IN_DATA_WIDTH;
    localparam bit PACKING = (PACK_MODE != 0) && (RATIO > 1);
    localparam int LANE_W  = lane_w(RATIO);
    localparam int FRAME_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
`ifdef AXIS_TKEEP_EN
    localparam int ENTRY_W = 1 + LANE_W + OUT_DATA_WIDTH;
`else
    localparam int ENTRY_W = 1 + OUT_DATA_WIDTH;
`endif

    typedef logic [LANE_W-1:0] lane_cnt_t;

    `AXIS_FIFO_CHECK(g_chk_ratio, (OUT_DATA_WIDTH >= IN_DATA_WIDTH) && (OUT_DATA_WIDTH % IN_DATA_WIDTH == 0),
                     "axis_pack_fifo: OUT_DATA_WIDTH must be a multiple of IN_DATA_WIDTH")
    `AXIS_FIFO_CHECK(g_chk_depth, is_pow2(DEPTH) && (DEPTH >= 2),
                     "axis_pack_fifo: DEPTH must be a power of two >= 2")
    `AXIS_FIFO_CHECK(g_chk_frame, FRAME_LEN >= 1,
                     "axis_pack_fifo: FRAME_LEN must be >= 1")
`ifdef AXIS_TKEEP_EN
    `AXIS_FIFO_CHECK(g_chk_keep, IN_DATA_WIDTH % 8 == 0,
                     "axis_pack_fifo: tkeep needs IN_DATA_WIDTH to be a multiple of 8")
`endif

    lane_cnt_t                 r_lane_cnt;
    logic [FRAME_W-1:0]        r_frame_cnt;
    logic [OUT_DATA_WIDTH-1:0] r_pack;
    logic [OUT_DATA_WIDTH-1:0] w_word;
    logic [ENTRY_W-1:0]        w_wdata;
    logic [ENTRY_W-1:0]        w_rdata;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_accept;
    logic                      w_frame_last;
    logic                      w_push_word;

    assign s_axis_tready = !w_full;
    assign w_accept      = s_axis_tvalid && !w_full;
    assign w_frame_last  = (r_frame_cnt == FRAME_W'(FRAME_LEN - 1));
    assign w_push_word   = w_accept &&
                           (!PACKING || (r_lane_cnt == lane_cnt_t'(RATIO - 1)) || w_frame_last);

    // Without packing r_lane_cnt stays 0 and r_pack stays 0, so the same lane mux zero-extends.
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
        assign w_word[gi*IN_DATA_WIDTH +: IN_DATA_WIDTH] =
            (r_lane_cnt == lane_cnt_t'(gi)) ? s_axis_tdata
                                            : r_pack[gi*IN_DATA_WIDTH +: IN_DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane_cnt  <= '0;
            r_frame_cnt <= '0;
            r_pack      <= '0;
        end else if (w_accept) begin
            r_frame_cnt <= w_frame_last ? '0 : r_frame_cnt + FRAME_W'(1);
            if (w_push_word) begin
                r_lane_cnt <= '0;
                r_pack     <= '0;
            end else begin
                r_lane_cnt <= r_lane_cnt + lane_cnt_t'(1);
                r_pack     <= w_word;
            end
        end
    end

`ifdef AXIS_TKEEP_EN
    assign w_wdata = {w_frame_last, r_lane_cnt + lane_cnt_t'(1), w_word};
`else
    assign w_wdata = {w_frame_last, w_word};
`endif

    axis_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push_word),
        .pop   (m_axis_tready),
        .wdata (w_wdata),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (fill_level)
    );

    assign m_axis_tvalid = !w_empty;
    assign m_axis_tdata  = w_rdata[OUT_DATA_WIDTH-1:0];
    assign m_axis_tlast  = w_rdata[ENTRY_W-1];

`ifdef AXIS_TKEEP_EN
    lane_cnt_t w_head_lanes;
    assign w_head_lanes = w_rdata[OUT_DATA_WIDTH +: LANE_W];

    // A byte is kept when its lane index is below the number of filled lanes.
    for (genvar gi = 0; gi < OUT_DATA_WIDTH / 8; gi++) begin : g_keep
        assign m_axis_tkeep[gi] = (w_head_lanes > lane_cnt_t'(gi / (IN_DATA_WIDTH / 8)));
    end
`endif

endmodule
